// File: rtl/ysyx_23060203_pkg.sv
// Shared GPR-scoreboard definitions: register count, default counter widths,
// counter type and the rd one-hot decode helper.
package ysyx_23060203_pkg;

  localparam int unsigned GPR_NUM   = 32;
  localparam int unsigned GPR_AW    = 5;
  localparam int unsigned CNT_W_DEF = 2;
  localparam int unsigned TOT_W_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] scb_cnt_t;

  // One-hot select of a GPR index; bit 0 is x0.
  function automatic logic [GPR_NUM-1:0] rd_onehot(input logic [GPR_AW-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/ysyx_23060203_scb_if.sv
// IDU/WBU <-> scoreboard signal bundle.
//   master: IDU/WBU side (drives rs/need/issue/retire, reads hazard status)
//   slave : scoreboard side
interface ysyx_23060203_scb_if
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned TOT_W = TOT_W_DEF
);
  logic [GPR_AW-1:0] rs1;
  logic              need_rs1;
  logic [GPR_AW-1:0] rs2;
  logic              need_rs2;
  logic              raw_stall;
  logic              issue_valid;
  logic [GPR_AW-1:0] issue_rd;
  logic              issue_ready;
  logic              retire_valid;
  logic [GPR_AW-1:0] retire_rd;
  logic              busy;
  logic [TOT_W-1:0]  inflight;
  logic              err;

  modport master (
    output rs1, need_rs1, rs2, need_rs2, issue_valid, issue_rd, retire_valid, retire_rd,
    input  raw_stall, issue_ready, busy, inflight, err
  );

  modport slave (
    input  rs1, need_rs1, rs2, need_rs2, issue_valid, issue_rd, retire_valid, retire_rd,
    output raw_stall, issue_ready, busy, inflight, err
  );
endinterface

// File: rtl/ysyx_23060203_scb_cnt.sv
// Per-register saturating pending-writer counter.
//   clock, reset : sync active-high reset
//   inc, dec     : one issue / one retire of this register this cycle
//   zero/full/one: count == 0 / all-ones / 1
//   underflow    : retire requested while nothing is pending
module ysyx_23060203_scb_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full,
  output logic one,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;
  logic             dec_ok;

  assign zero      = (cnt == '0);
  assign full      = (cnt == '1);
  assign one       = (cnt == CNT_W'(1));
  assign dec_ok    = dec & ~zero;
  assign underflow = dec & zero;

  // Simultaneous inc and valid dec cancel; never wrap in either direction.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec_ok && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec_ok && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060203_scb.sv
// GPR scoreboard: per-register pending-writer counters gate IDU issue.
//   clock, reset : sync active-high reset
//   bus (slave)  : rs1/rs2 queries -> raw_stall; issue handshake -> issue_ready;
//                  WBU retire; busy/inflight/err status
// Optional build macro: YSYX_23060203_SCB_BYPASS_EN lets a retiring last
// writer clear the hazard in the retire cycle (WBU forwards write data).
module ysyx_23060203_scb
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TOT_W = TOT_W_DEF
) (
  input logic                 clock,
  input logic                 reset,
  ysyx_23060203_scb_if.slave  bus
);

  logic [GPR_NUM-1:0] zero_v, full_v, one_v, unf_v, inc_v, dec_v, pend_v;
  logic               issue_fire;
  logic               same_rd;
  logic               tot_inc, tot_dec, tot_ovf, err_set;
  logic [TOT_W-1:0]   tot, tot_nxt;
  logic               err_q;
  logic               unused_x0;

  // x0 has no counter: always empty, never full.
  assign zero_v[0] = 1'b1;
  assign full_v[0] = 1'b0;
  assign one_v[0]  = 1'b0;
  assign unf_v[0]  = 1'b0;

  assign issue_fire = bus.issue_valid & bus.issue_ready & (|bus.issue_rd);
  assign inc_v      = issue_fire       ? rd_onehot(bus.issue_rd)  : '0;
  assign dec_v      = bus.retire_valid ? rd_onehot(bus.retire_rd) : '0;

  for (genvar i = 1; i < GPR_NUM; i++) begin : g_cnt
    ysyx_23060203_scb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_v[i]),
      .dec       (dec_v[i]),
      .zero      (zero_v[i]),
      .full      (full_v[i]),
      .one       (one_v[i]),
      .underflow (unf_v[i])
    );
  end

  // A full counter still accepts an issue when the same register retires now.
  assign same_rd         = bus.retire_valid & (bus.retire_rd == bus.issue_rd);
  assign bus.issue_ready = ~(|bus.issue_rd) | ~full_v[bus.issue_rd]
                         | (same_rd & ~zero_v[bus.issue_rd]);

  // Pending mask; depends only on state and retire, never on issue.
  always_comb begin
`ifdef YSYX_23060203_SCB_BYPASS_EN
    pend_v = ~zero_v & ~(dec_v & one_v);
`else
    pend_v = ~zero_v;
`endif
  end

  assign bus.raw_stall = (bus.need_rs1 & (|bus.rs1) & pend_v[bus.rs1])
                       | (bus.need_rs2 & (|bus.rs2) & pend_v[bus.rs2]);

  // Total in-flight count; saturates rather than wrapping.
  assign tot_inc = issue_fire;
  assign tot_dec = bus.retire_valid & (|bus.retire_rd) & ~zero_v[bus.retire_rd];
  assign tot_ovf = tot_inc & ~tot_dec & (tot == '1);

  always_comb begin
    tot_nxt = tot;
    if (tot_inc && !tot_dec && !tot_ovf) begin
      tot_nxt = tot + TOT_W'(1);
    end else if (!tot_inc && tot_dec) begin
      tot_nxt = tot - TOT_W'(1);
    end
  end

  assign err_set = (|unf_v) | (bus.issue_valid & ~bus.issue_ready) | tot_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      tot   <= '0;
      err_q <= 1'b0;
    end else begin
      tot   <= tot_nxt;
      err_q <= err_q | err_set;
    end
  end

  assign bus.busy     = |tot;
  assign bus.inflight = tot;
  assign bus.err      = err_q;

  assign unused_x0 = ^{inc_v[0], dec_v[0], one_v};

endmodule
